// File: rtl/btn_pkg.sv
// btn_pkg: state encoding, default board timing and counter-width helpers
// shared by the button conditioning logic. Rev 1.0
`default_nettype none

package btn_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20;
  localparam int unsigned DEF_HOLD_CYCLES     = 100;
  localparam int unsigned DEF_REPEAT_CYCLES   = 50;
  localparam bit          DEF_BTN_ACTIVE_LOW  = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous board inputs,
// with a configurable reset value. Rev 1.0
`default_nettype none

module sync_2ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: synchronises and debounces a push-button, producing a
// clean level, press/release pulses and auto-repeat pulses. Rev 1.0
`default_nettype none

module button_debounce_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

  logic          btn_act;
  logic          s;
  state_t        state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic          from_held, from_held_nx;
  logic          level_nx, press_nx, release_nx, repeat_nx, long_nx;

  assign btn_act = btn ^ BTN_ACTIVE_LOW;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (btn_act),
    .q     (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      from_held     <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nx;
      dcnt          <= dcnt_nx;
      hcnt          <= hcnt_nx;
      from_held     <= from_held_nx;
      level         <= level_nx;
      press         <= press_nx;
      release_pulse <= release_nx;
      repeat_pulse  <= repeat_nx;
      long_press    <= long_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    dcnt_nx      = dcnt;
    hcnt_nx      = hcnt;
    from_held_nx = from_held;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
    repeat_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = PRESS_WAIT;
          dcnt_nx  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
        end else if (dcnt == D_LAST) begin
          state_nx = PRESSED;
          hcnt_nx  = '0;
          press_nx = 1'b1;
        end else begin
          dcnt_nx = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nx     = RELEASE_WAIT;
          dcnt_nx      = '0;
          from_held_nx = 1'b0;
        end else if (hcnt == H_LAST) begin
          state_nx  = HELD;
          hcnt_nx   = '0;
          repeat_nx = 1'b1;
        end else begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_nx     = RELEASE_WAIT;
          dcnt_nx      = '0;
          from_held_nx = 1'b1;
        end else if (hcnt == R_LAST) begin
          hcnt_nx   = '0;
          repeat_nx = 1'b1;
        end else begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A release glitch resumes the hold timing where it left off.
        if (s) begin
          state_nx = from_held ? HELD : PRESSED;
        end else if (dcnt == D_LAST) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end else begin
          dcnt_nx = dcnt + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    level_nx = (state_nx == PRESSED) || (state_nx == HELD) || (state_nx == RELEASE_WAIT);
    long_nx  = (state_nx == HELD) || ((state_nx == RELEASE_WAIT) && from_held_nx);
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_fsm.sv
// tb_button_debounce_fsm: directed checks of debounce, pulse timing,
// auto-repeat, release glitch and reset behaviour. Rev 1.0
`default_nettype none

module tb_button_debounce_fsm;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic level, press, release_pulse, repeat_pulse, long_press;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce_fsm #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (5),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .long_press    (long_press)
  );

  // Observed vector order: {level, press, release, repeat, long_press}
  task automatic chk(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {level, press, release_pulse, repeat_pulse, long_press};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    btn   = 1'b0;

    // Reset held with button pressed: everything stays cleared.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("reset_hold_%0d", k), 5'b00000);
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_reset_press_%0d", k), {k >= 6, k == 6, 1'b0, 1'b0, 1'b0});
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_reset_release_%0d", k), {k < 6, 1'b0, k == 6, 1'b0, 1'b0});
    end

    // Clean press for 12 cycles then release.
    btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("clean_press_%0d", k), {k >= 6, k == 6, 1'b0, 1'b0, 1'b0});
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("clean_release_%0d", k), {k < 6, 1'b0, k == 6, 1'b0, 1'b0});
    end

    // Bounce: 2 cycles pressed / 2 released, never long enough to accept.
    for (int k = 0; k < 30; k++) begin
      btn = (k < 20) ? logic'((k / 2) % 2) : 1'b1;
      tick();
      chk($sformatf("bounce_%0d", k), 5'b00000);
    end

    // Long press with auto-repeat.
    btn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("long_hold_%0d", k),
          {k >= 6, k == 6, 1'b0,
           (k == 16) || (k == 21) || (k == 26) || (k == 31) || (k == 36),
           k >= 16});
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("long_release_%0d", k), {k < 6, 1'b0, k == 6, k == 1, k < 6});
    end

    // Release glitch at edges 14..15: hold timing frozen, first repeat at 19.
    for (int k = 0; k < 31; k++) begin
      btn = ((k == 14) || (k == 15)) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("glitch_hold_%0d", k),
          {k >= 6, k == 6, 1'b0, (k == 19) || (k == 24) || (k == 29), k >= 19});
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("glitch_release_%0d", k), {k < 6, 1'b0, k == 6, 1'b0, k < 6});
    end

    // Reset asserted mid-hold clears outputs at once, no release afterwards.
    btn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("mid_hold_%0d", k),
          {k >= 6, k == 6, 1'b0, k == 16, k >= 16});
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_clear", 5'b00000);
    btn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_reset_hold_%0d", k), 5'b00000);
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("after_mid_reset_%0d", k), 5'b00000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
